// File: rtl/icache_ic_pkg.sv
// Shared types and sizes for the thread-processor to ICache interconnect.
package icache_ic_pkg;

    localparam int unsigned NUM_TP = 32;
    localparam int unsigned SEL_W  = 5;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RELEASE
    } arb_state_t;

    typedef logic [SEL_W-1:0] tp_sel_t;

endpackage : icache_ic_pkg

// File: rtl/rr_priority_pick.sv
// Round-robin pick: first set request scanning last+1, last+2, ... with wrap.
// Purely combinational so it can be shared with the data-return demux arbiter.
module rr_priority_pick #(
    parameter int unsigned NUM_REQ = icache_ic_pkg::NUM_TP,
    parameter int unsigned SEL_W   = icache_ic_pkg::SEL_W
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last,
    output logic [SEL_W-1:0]   winner,
    output logic               found
);

    // Scan from the slot after the previous owner; the previous owner comes last.
    always_comb begin
        int unsigned idx;
        idx    = 0;
        winner = '0;
        found  = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = (32'(last) + k) % NUM_REQ;
            if (!found && req[SEL_W'(idx)]) begin
                found  = 1'b1;
                winner = SEL_W'(idx);
            end
        end
    end

endmodule : rr_priority_pick

// File: rtl/icache_rr_arbiter.sv
// Round-robin arbiter feeding the 32:1 ICache address mux.
// Holds select/enable until the ICache acks, then inserts one idle turnaround
// cycle so the wired-OR address bus never sees two drivers.
// Optional: define ARB_TIMEOUT_EN to abort a BUSY owner after TIMEOUT_CYCLES.
module icache_rr_arbiter #(
    parameter int unsigned NUM_REQ        = icache_ic_pkg::NUM_TP,
    parameter int unsigned SEL_W          = icache_ic_pkg::SEL_W,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               cache_ready,
    input  logic               cache_ack,
    output logic [SEL_W-1:0]   selectLine,
    output logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic               busy,
    output logic               timeout_err
);

    import icache_ic_pkg::*;

    localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(NUM_REQ - 1);

    arb_state_t         state_q, state_d;
    logic [SEL_W-1:0]   last_q, last_d;
    logic [SEL_W-1:0]   sel_d;
    logic               en_d, busy_d;
    logic [NUM_REQ-1:0] grant_d;
    logic [SEL_W-1:0]   winner;
    logic               found;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             terr_d;
`endif

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .SEL_W   (SEL_W)
    ) u_pick (
        .req    (req),
        .last   (last_q),
        .winner (winner),
        .found  (found)
    );

    // Next-state and next-output decode.
    always_comb begin
        state_d = state_q;
        sel_d   = selectLine;
        en_d    = enable;
        grant_d = grant;
        busy_d  = busy;
        last_d  = last_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        terr_d  = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (found && cache_ready) begin
                    state_d = BUSY;
                    sel_d   = winner;
                    en_d    = 1'b1;
                    grant_d = NUM_REQ'(1) << winner;
                    busy_d  = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            BUSY: begin
                if (cache_ack) begin
                    state_d = RELEASE;
                    en_d    = 1'b0;
                    grant_d = '0;
                    last_d  = selectLine;
                end
`ifdef ARB_TIMEOUT_EN
                // Abort a hung owner; it also loses priority like a normal release.
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = RELEASE;
                    en_d    = 1'b0;
                    grant_d = '0;
                    last_d  = selectLine;
                    terr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            RELEASE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                en_d    = 1'b0;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, pointer and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            last_q     <= LAST_RST;
            selectLine <= '0;
            enable     <= 1'b0;
            grant      <= '0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            selectLine <= sel_d;
            enable     <= en_d;
            grant      <= grant_d;
            busy       <= busy_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // BUSY cycle counter and one-cycle abort pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            timeout_err <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            timeout_err <= terr_d;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule : icache_rr_arbiter
